// File: rtl/div_pkg.sv
// Shared helpers for the programmable clock divider: select-width sizing and ratio sanitising.
// No logic of its own; latency and backpressure belong to the modules that import it.
package div_pkg;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // A divide ratio of zero is meaningless, so it runs as divide-by-one.
    function automatic logic [31:0] ratio_fix(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/div_clk_ch.sv
// One divider channel: counter, active/pending ratio, registered clk_en strobe and square wave.
// Latency: outputs registered one cycle behind cnt; no backpressure, free-running.
module div_clk_ch
    import div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [DIV_W-1:0] val,
    input  logic             sync,
    output logic             pend,
    output logic             clk_en,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] DEF_R = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W:0]   half;
    logic             wrap;
    logic             hi;

    assign half = ({1'b0, ratio} + 1'b1) >> 1;
    assign wrap = (cnt == ratio - ONE);
    assign hi   = (ratio != ONE) && ({1'b0, cnt} < half);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            ratio    <= DEF_R;
            pend_val <= DEF_R;
            pend     <= 1'b0;
            clk_en   <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            // Sync wins over the wrap and suppresses the strobe of the aborted period.
            if (sync) begin
                cnt     <= '0;
                clk_en  <= 1'b0;
                clk_out <= 1'b0;
                if (pend) ratio <= pend_val;
            end else if (wrap) begin
                cnt     <= '0;
                clk_en  <= 1'b1;
                clk_out <= hi;
                if (pend) ratio <= pend_val;
            end else begin
                cnt     <= cnt + ONE;
                clk_en  <= 1'b0;
                clk_out <= hi;
            end

            // A load landing on a boundary stays pending for the next one.
            if (ld) begin
                pend_val <= val;
                pend     <= 1'b1;
            end else if (sync || wrap) begin
                pend     <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/div_clk_gen.sv
// NCH programmable glitch-free clock dividers with phase sync, plus counted POR release.
// Latency: one cycle from load/sync to state; no backpressure, loads are never stalled.
module div_clk_gen
    import div_pkg::*;
#(
    parameter int  NCH     = 2,
    parameter int  DIV_W   = 8,
    parameter int  DEF_DIV = 2,
    parameter int  POR_CYC = 16,
    localparam int CH_W    = ch_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_ld,
    input  logic [CH_W-1:0]  div_sel,
    input  logic [DIV_W-1:0] div_val,
    input  logic             sync,
    output logic [NCH-1:0]   div_pend,
    output logic [NCH-1:0]   clk_en,
    output logic [NCH-1:0]   clk_out,
    output logic             rst_out
);

    localparam int              POR_W   = $clog2(POR_CYC + 1);
    localparam logic [POR_W-1:0] POR_MAX = POR_W'(POR_CYC);

    logic             ld_ok;
    logic [DIV_W-1:0] val_fix;
    logic [POR_W-1:0] por_cnt;

    assign ld_ok   = div_ld && (32'(div_sel) < NCH);
    assign val_fix = DIV_W'(ratio_fix(32'(div_val)));

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        div_clk_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ld      (ld_ok && (32'(div_sel) == i)),
            .val     (val_fix),
            .sync    (sync),
            .pend    (div_pend[i]),
            .clk_en  (clk_en[i]),
            .clk_out (clk_out[i])
        );
    end

    // Core reset drops on the same edge the counter reaches its limit, then holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            por_cnt <= '0;
            rst_out <= 1'b1;
        end else if (por_cnt != POR_MAX) begin
            por_cnt <= por_cnt + 1'b1;
            rst_out <= (por_cnt + 1'b1) != POR_MAX;
        end
    end

endmodule
